// File: rtl/ifft_out_serializer.sv
// rtl/ifft_out_serializer.sv - walks the IFFT core's point select and streams captured results
// with valid/ready backpressure, an index and a last-of-frame marker.
module ifft_out_serializer #(
  parameter int DATA_W = 12,
  parameter int N_PTS  = 8,
  parameter int IDX_W  = 3,
  parameter int FCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [IDX_W-1:0]  sel,
  input  logic [DATA_W-1:0] yr_in,
  input  logic [DATA_W-1:0] yi_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data_r,
  output logic [DATA_W-1:0] m_data_i,
  output logic [IDX_W-1:0]  m_index,
  output logic              m_last,
  output logic              busy,
  output logic              done,
  output logic [FCNT_W-1:0] frame_cnt
);

  typedef enum logic [2:0] {IDLE, WAIT, CAPT, OUT, FIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_PTS - 1);

  state_t              state, state_n;
  logic [IDX_W-1:0]    k, k_n;
  logic [IDX_W-1:0]    sel_n;
  logic                valid_n, last_n, busy_n, done_n;
  logic [DATA_W-1:0]   data_r_n, data_i_n;
  logic [IDX_W-1:0]    index_n;
  logic [FCNT_W-1:0]   fcnt_n;

  // Every output is a plain register; the comb block only computes next values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      k         <= '0;
      sel       <= '0;
      m_valid   <= 1'b0;
      m_data_r  <= '0;
      m_data_i  <= '0;
      m_index   <= '0;
      m_last    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state     <= state_n;
      k         <= k_n;
      sel       <= sel_n;
      m_valid   <= valid_n;
      m_data_r  <= data_r_n;
      m_data_i  <= data_i_n;
      m_index   <= index_n;
      m_last    <= last_n;
      busy      <= busy_n;
      done      <= done_n;
      frame_cnt <= fcnt_n;
    end
  end

  always_comb begin
    state_n  = state;
    k_n      = k;
    sel_n    = sel;
    valid_n  = m_valid;
    data_r_n = m_data_r;
    data_i_n = m_data_i;
    index_n  = m_index;
    last_n   = m_last;
    busy_n   = busy;
    done_n   = done;
    fcnt_n   = frame_cnt;
    case (state)
      IDLE: begin
        if (start) begin
          sel_n   = '0;
          k_n     = '0;
          busy_n  = 1'b1;
          state_n = WAIT;
        end
      end
      // The core registers y_k on this edge, so the value is only usable in CAPT.
      WAIT: state_n = CAPT;
      CAPT: begin
        data_r_n = yr_in;
        data_i_n = yi_in;
        index_n  = k;
        last_n   = (k == LAST_IDX);
        valid_n  = 1'b1;
        state_n  = OUT;
      end
      OUT: begin
        if (m_ready) begin
          valid_n = 1'b0;
          last_n  = 1'b0;
          if (k != LAST_IDX) begin
            k_n     = k + IDX_W'(1);
            sel_n   = k + IDX_W'(1);
            state_n = WAIT;
          end else begin
            done_n  = 1'b1;
            state_n = FIN;
          end
        end
      end
      FIN: begin
        done_n  = 1'b0;
        busy_n  = 1'b0;
        fcnt_n  = frame_cnt + FCNT_W'(1);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifft_out_serializer.sv
// tb/tb_ifft_out_serializer.sv - randomized bench for ifft_out_serializer with a table-driven
// core stub and a frame-level scoreboard.
module tb_ifft_out_serializer;

  localparam int DATA_W = 12;
  localparam int N_PTS  = 8;
  localparam int IDX_W  = 3;
  localparam int FCNT_W = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [IDX_W-1:0]  sel;
  logic [DATA_W-1:0] yr_in, yi_in;
  logic              m_valid, m_ready;
  logic [DATA_W-1:0] m_data_r, m_data_i;
  logic [IDX_W-1:0]  m_index;
  logic              m_last, busy, done;
  logic [FCNT_W-1:0] frame_cnt;

  ifft_out_serializer #(.DATA_W(DATA_W), .N_PTS(N_PTS), .IDX_W(IDX_W), .FCNT_W(FCNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sel(sel), .yr_in(yr_in), .yi_in(yi_in),
    .m_valid(m_valid), .m_ready(m_ready), .m_data_r(m_data_r), .m_data_i(m_data_i),
    .m_index(m_index), .m_last(m_last), .busy(busy), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Core stub: one result per sel, registered on each rising edge.
  logic [DATA_W-1:0] tr [N_PTS];
  logic [DATA_W-1:0] ti [N_PTS];
  always_ff @(posedge clk) begin
    yr_in <= tr[sel];
    yi_in <= ti[sel];
  end

  typedef struct {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] i;
    logic [IDX_W-1:0]  idx;
    logic              last;
  } smp_t;

  smp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   hs_in_frame = 0;
  logic [FCNT_W-1:0] exp_fcnt = '0;

  int   rdy_mode = 0;
  int   stall_left = 0;
  int   stall_idx = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int p = 0; p < N_PTS; p++) begin
      smp_t s;
      s.r = tr[p];
      s.i = ti[p];
      s.idx = IDX_W'(p);
      s.last = (p == N_PTS - 1);
      exp_q.push_back(s);
    end
  endtask

  task automatic issue_start();
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    if (!done) chk("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idx(input int idx, input string tag);
    int n = 0;
    while (!(m_valid && m_index == IDX_W'(idx)) && n < 400) begin
      tick();
      n++;
    end
    if (!(m_valid && m_index == IDX_W'(idx))) chk(tag, 64'd0, 64'd1);
  endtask

  // Sink readiness: constant or ~30% random, with an optional stall on one index.
  initial begin
    m_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (stall_left > 0 && m_valid && m_index == IDX_W'(stall_idx)) begin
        m_ready = 1'b0;
        stall_left--;
      end else if (rdy_mode == 1) begin
        m_ready = ($urandom_range(0, 99) < 30);
      end else begin
        m_ready = 1'b1;
      end
    end
  end

  // Scoreboard and stream-protocol monitor, sampled mid-cycle.
  logic              prev_stall = 1'b0;
  logic [DATA_W-1:0] prev_r, prev_i;
  logic [IDX_W-1:0]  prev_idx, prev_sel;
  logic              prev_last;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", 64'(m_valid), 64'd1);
        chk("stall_data", {m_data_r, m_data_i, m_index, m_last, sel},
            {prev_r, prev_i, prev_idx, prev_last, prev_sel});
      end
      if (m_valid) chk("sel_vs_index", 64'(sel), 64'(m_index));
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_sample", 64'(m_index), 64'hFFFF);
        end else begin
          smp_t e;
          e = exp_q.pop_front();
          chk("sample", {m_data_r, m_data_i, m_index, m_last}, {e.r, e.i, e.idx, e.last});
          hs_in_frame++;
          if (hs_in_frame == N_PTS) begin
            hs_in_frame = 0;
            exp_fcnt = exp_fcnt + 1'b1;
          end
        end
      end
      if (done) chk("done_frame_complete", 64'(exp_q.size() + hs_in_frame), 64'd0);
      prev_stall = m_valid && !m_ready;
      prev_r = m_data_r; prev_i = m_data_i; prev_idx = m_index;
      prev_last = m_last; prev_sel = sel;
    end
  end

  initial begin
    int n;
    logic saw_wrap;
    rst_n = 1'b0;
    start = 1'b0;
    for (int p = 0; p < N_PTS; p++) begin
      tr[p] = DATA_W'($urandom);
      ti[p] = DATA_W'($urandom);
    end
    tr[0] = 12'h040;
    #3;
    chk("reset_outputs", {sel, m_valid, m_data_r, m_data_i, m_index, m_last, busy, done, frame_cnt}, 64'd0);
    #14;
    rst_n = 1'b1;
    tick();

    // Single frame, sink always ready: latency and frame length.
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    chk("busy_after_start", 64'(busy), 64'd1);
    tick(); n++;
    chk("valid_cycle2", 64'(m_valid), 64'd0);
    tick(); n++;
    chk("first_sample", {m_valid, m_index, m_data_r}, {1'b1, 3'd0, 12'h040});
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk("done_cycle", 64'(n), 64'd25);
    tick();
    chk("done_one_cycle", {done, busy}, 64'd0);
    chk("fcnt_frame1", 64'(frame_cnt), 64'(exp_fcnt));

    // Stub pattern tied to sel checks capture alignment.
    for (int p = 0; p < N_PTS; p++) begin
      tr[p] = DATA_W'(p * 16 + 1);
      ti[p] = ~tr[p];
    end
    issue_start();
    wait_done(200);
    tick();
    chk("fcnt_frame2", 64'(frame_cnt), 64'(exp_fcnt));

    // Random backpressure with a long stall on index 4.
    for (int p = 0; p < N_PTS; p++) begin
      tr[p] = DATA_W'($urandom);
      ti[p] = DATA_W'($urandom);
    end
    rdy_mode = 1;
    stall_idx = 4;
    stall_left = 20;
    issue_start();
    wait_done(1000);
    tick();
    chk("fcnt_random", 64'(frame_cnt), 64'(exp_fcnt));
    rdy_mode = 0;
    stall_left = 0;

    // start mid-frame and in FIN must be dropped.
    issue_start();
    wait_idx(2, "reach_idx2");
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(200);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("fin_start_dropped", 64'(busy), 64'd0);
    repeat (40) tick();
    chk("single_frame", {busy, frame_cnt}, {1'b0, exp_fcnt});
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while stalled at index 5.
    stall_idx = 5;
    stall_left = 1000;
    issue_start();
    wait_idx(5, "reach_idx5");
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    hs_in_frame = 0;
    exp_fcnt = '0;
    stall_left = 0;
    #1;
    chk("async_reset", {sel, m_valid, m_data_r, m_data_i, m_index, m_last, busy, done, frame_cnt}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    issue_start();
    wait_done(200);
    tick();
    chk("fcnt_after_reset", 64'(frame_cnt), 64'd1);

    // 256 back-to-back frames, frame counter wraps.
    saw_wrap = 1'b0;
    for (int f = 0; f < 256; f++) begin
      issue_start();
      wait_done(200);
      tick();
      chk("fcnt_b2b", 64'(frame_cnt), 64'(exp_fcnt));
      if (frame_cnt == '0) saw_wrap = 1'b1;
    end
    chk("fcnt_wrapped", 64'(saw_wrap), 64'd1);
    chk("fcnt_final", 64'(frame_cnt), 64'd1);
    chk("final_queue", 64'(exp_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
